// File: rtl/pc_sequencer.sv
// Purpose: fetch-stage program counter; steps by STEP per accepted fetch, takes aligned redirects, flags wrong-path fetches.
// Latency: all outputs registered except next_pc (combinational fetch_pc + STEP); one BOOT cycle after reset before the first offer.
// Backpressure: an offer (fetch_valid=1) is held until fetch_ready; stall and redirects are deferred until that handshake.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   stall                    hold PC and stop issuing once the current offer is accepted
//   redirect_valid/_pc       branch/jump target; low ALIGN_BITS are forced to zero
//   fetch_ready              instruction memory accepts fetch_pc this cycle
//   fetch_valid, fetch_pc    registered fetch request
//   next_pc                  fetch_pc + STEP modulo 2^WIDTH
//   redirect_pending         a redirect is stored, waiting for the current offer to be accepted
//   fetch_kill               1-cycle pulse: the fetch accepted last cycle was wrong-path
//   wrap                     1-cycle pulse: the last increment carried out of WIDTH
module pc_sequencer #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      STEP       = 4,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned      ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_pc,
    output logic [WIDTH-1:0] next_pc,
    output logic             redirect_pending,
    output logic             fetch_kill,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    // Clears the low ALIGN_BITS; ALIGN_BITS=0 yields an all-ones mask.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic             pend_q, pend_d;
    logic             kill_q, kill_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] target;

    assign sum              = {1'b0, fetch_pc} + (WIDTH+1)'(STEP);
    assign next_pc          = sum[WIDTH-1:0];
    assign target           = redirect_pc & ALIGN_MASK;
    // Decode of the state flop only, so fetch_valid is glitch-free from a register.
    assign fetch_valid      = (state_q == S_RUN);
    assign redirect_pending = pend_q;
    assign fetch_kill       = kill_q;
    assign wrap             = wrap_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = fetch_pc;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        kill_d    = 1'b0;
        wrap_d    = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                // Nothing offered yet, so a redirect just retargets the first fetch.
                if (redirect_valid) pc_d = target;
            end
            S_HALT: begin
                if (!stall)         state_d = S_RUN;
                if (redirect_valid) pc_d    = target;
            end
            S_RUN: begin
                if (fetch_ready) begin
                    state_d = stall ? S_HALT : S_RUN;
                    pend_d  = 1'b0;
                    // A same-cycle redirect is newer than any stored one, so it wins.
                    if (redirect_valid) begin
                        pc_d   = target;
                        kill_d = 1'b1;
                    end else if (pend_q) begin
                        pc_d   = pend_pc_q;
                        kill_d = 1'b1;
                    end else begin
                        pc_d   = next_pc;
                        wrap_d = sum[WIDTH];
                    end
                end else if (redirect_valid) begin
                    // Offer must not change while unaccepted; park the newest target.
                    pend_d    = 1'b1;
                    pend_pc_d = target;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_BOOT;
            fetch_pc  <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            kill_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fetch_pc  <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            kill_q    <= kill_d;
            wrap_q    <= wrap_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: checks pc_sequencer in three parameterisations (default, near-wrap reset PC, word-addressed STEP=1).
// Latency: outputs sampled 1 ns after each rising edge; reset checked 1 ns after assertion.
// Backpressure: fetch_ready is driven by table, hand sequences and random stimulus.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_ready;

    logic [2:0]       d_valid, d_pend, d_kill, d_wrap;
    logic [2:0][31:0] d_pc, d_npc;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(32), .STEP(4), .RESET_PC(32'h0000_0000), .ALIGN_BITS(2)) u_dut0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fetch_ready(fetch_ready), .fetch_valid(d_valid[0]),
        .fetch_pc(d_pc[0]), .next_pc(d_npc[0]), .redirect_pending(d_pend[0]),
        .fetch_kill(d_kill[0]), .wrap(d_wrap[0]));

    pc_sequencer #(.WIDTH(32), .STEP(4), .RESET_PC(32'hFFFF_FFF8), .ALIGN_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fetch_ready(fetch_ready), .fetch_valid(d_valid[1]),
        .fetch_pc(d_pc[1]), .next_pc(d_npc[1]), .redirect_pending(d_pend[1]),
        .fetch_kill(d_kill[1]), .wrap(d_wrap[1]));

    pc_sequencer #(.WIDTH(32), .STEP(1), .RESET_PC(32'hFFFF_FFFE), .ALIGN_BITS(0)) u_dut2 (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fetch_ready(fetch_ready), .fetch_valid(d_valid[2]),
        .fetch_pc(d_pc[2]), .next_pc(d_npc[2]), .redirect_pending(d_pend[2]),
        .fetch_kill(d_kill[2]), .wrap(d_wrap[2]));

    // Per-instance configuration seen by the reference model.
    logic [31:0] cfg_step[3];
    logic [31:0] cfg_mask[3];
    logic [31:0] cfg_rpc[3];

    // Reference model: "offering" means a fetch request is outstanding; the
    // single-entry parked redirect is a valid bit plus target.
    logic [31:0] m_pc[3];
    bit          m_boot[3];
    bit          m_offer[3];
    bit          m_pv[3];
    logic [31:0] m_pt[3];
    bit          m_kill[3];
    bit          m_wrap[3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pc[i]    = cfg_rpc[i];
            m_boot[i]  = 1'b1;
            m_offer[i] = 1'b0;
            m_pv[i]    = 1'b0;
            m_pt[i]    = '0;
            m_kill[i]  = 1'b0;
            m_wrap[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        logic [32:0] s;
        logic [31:0] tgt;
        tgt       = redirect_pc & cfg_mask[i];
        m_kill[i] = 1'b0;
        m_wrap[i] = 1'b0;
        if (!m_offer[i]) begin
            if (redirect_valid) m_pc[i] = tgt;
            if (m_boot[i] || !stall) m_offer[i] = 1'b1;
            m_boot[i] = 1'b0;
        end else if (fetch_ready) begin
            if (redirect_valid) begin
                m_pc[i]   = tgt;
                m_kill[i] = 1'b1;
            end else if (m_pv[i]) begin
                m_pc[i]   = m_pt[i];
                m_kill[i] = 1'b1;
            end else begin
                s         = {1'b0, m_pc[i]} + {1'b0, cfg_step[i]};
                m_pc[i]   = s[31:0];
                m_wrap[i] = s[32];
            end
            m_pv[i]    = 1'b0;
            m_offer[i] = !stall;
        end else if (redirect_valid) begin
            m_pt[i] = tgt;
            m_pv[i] = 1'b1;
        end
    endtask

    task automatic check_model(input int i);
        logic [31:0] enpc;
        enpc = m_pc[i] + cfg_step[i];
        n_vec++;
        if (d_valid[i] !== m_offer[i] || d_pc[i] !== m_pc[i] || d_npc[i] !== enpc ||
            d_pend[i] !== m_pv[i] || d_kill[i] !== m_kill[i] || d_wrap[i] !== m_wrap[i]) begin
            n_bad++;
            $display("FAIL model inst%0d t=%0t: got v=%b pc=%h npc=%h pend=%b kill=%b wrap=%b, want v=%b pc=%h npc=%h pend=%b kill=%b wrap=%b",
                     i, $time, d_valid[i], d_pc[i], d_npc[i], d_pend[i], d_kill[i], d_wrap[i],
                     m_offer[i], m_pc[i], enpc, m_pv[i], m_kill[i], m_wrap[i]);
        end
    endtask

    task automatic check_const(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %h want %h", name, $time, got, want);
        end
    endtask

    task automatic tick();
        for (int i = 0; i < 3; i++) model_step(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_model(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) check_model(i);
        @(negedge clk);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fetch_ready    = 1'b0;
        rst            = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        ready;
        logic        ev;
        logic [31:0] epc;
        logic        epend;
        logic        ekill;
        logic        ewrap;
    } vec_t;

    function automatic vec_t mkv(logic s, logic rv, logic [31:0] rpc, logic rdy,
                                 logic ev, logic [31:0] epc, logic ep, logic ek, logic ew);
        vec_t v;
        v.stall = s;  v.rv = rv;  v.rpc = rpc;  v.ready = rdy;
        v.ev = ev;  v.epc = epc;  v.epend = ep;  v.ekill = ek;  v.ewrap = ew;
        return v;
    endfunction

    vec_t        tbl[23];
    logic [31:0] exp_pc[3][4];
    logic        exp_wr[3][4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_step[0] = 32'd4; cfg_mask[0] = 32'hFFFF_FFFC; cfg_rpc[0] = 32'h0000_0000;
        cfg_step[1] = 32'd4; cfg_mask[1] = 32'hFFFF_FFFC; cfg_rpc[1] = 32'hFFFF_FFF8;
        cfg_step[2] = 32'd1; cfg_mask[2] = 32'hFFFF_FFFF; cfg_rpc[2] = 32'hFFFF_FFFE;

        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; fetch_ready = 1'b0;

        //              stall rv  rpc          rdy  valid pc          pend kill wrap
        tbl[0]  = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0); // BOOT -> RUN
        tbl[1]  = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h4,     1'b0, 1'b0, 1'b0);
        tbl[2]  = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h8,     1'b0, 1'b0, 1'b0);
        tbl[3]  = mkv(1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     1'b0, 1'b0, 1'b0); // held offer
        tbl[4]  = mkv(1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     1'b0, 1'b0, 1'b0);
        tbl[5]  = mkv(1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     1'b0, 1'b0, 1'b0);
        tbl[6]  = mkv(1'b1, 1'b0, 32'h0,     1'b1, 1'b0, 32'hC,     1'b0, 1'b0, 1'b0); // fetch 8, halt
        tbl[7]  = mkv(1'b1, 1'b0, 32'h0,     1'b1, 1'b0, 32'hC,     1'b0, 1'b0, 1'b0);
        tbl[8]  = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'hC,     1'b0, 1'b0, 1'b0);
        tbl[9]  = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h10,    1'b0, 1'b0, 1'b0);
        tbl[10] = mkv(1'b0, 1'b1, 32'h103,   1'b0, 1'b1, 32'h10,    1'b1, 1'b0, 1'b0); // park 0x100
        tbl[11] = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h100,   1'b0, 1'b1, 1'b0);
        tbl[12] = mkv(1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h100,   1'b0, 1'b0, 1'b0);
        tbl[13] = mkv(1'b0, 1'b1, 32'h200,   1'b0, 1'b1, 32'h100,   1'b1, 1'b0, 1'b0);
        tbl[14] = mkv(1'b0, 1'b1, 32'h300,   1'b0, 1'b1, 32'h100,   1'b1, 1'b0, 1'b0); // overwrite
        tbl[15] = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h300,   1'b0, 1'b1, 1'b0);
        tbl[16] = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h304,   1'b0, 1'b0, 1'b0); // single kill
        tbl[17] = mkv(1'b1, 1'b1, 32'h40F,   1'b1, 1'b0, 32'h40C,   1'b0, 1'b1, 1'b0); // redirect on fetch
        tbl[18] = mkv(1'b1, 1'b1, 32'h500,   1'b1, 1'b0, 32'h500,   1'b0, 1'b0, 1'b0); // redirect in HALT
        tbl[19] = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h500,   1'b0, 1'b0, 1'b0);
        tbl[20] = mkv(1'b0, 1'b1, 32'h600,   1'b0, 1'b1, 32'h500,   1'b1, 1'b0, 1'b0);
        tbl[21] = mkv(1'b0, 1'b1, 32'h700,   1'b1, 1'b1, 32'h700,   1'b0, 1'b1, 1'b0); // newest wins
        tbl[22] = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h704,   1'b0, 1'b0, 1'b0);

        exp_pc[0][0] = 32'h0;         exp_pc[0][1] = 32'h4;         exp_pc[0][2] = 32'h8; exp_pc[0][3] = 32'hC;
        exp_pc[1][0] = 32'hFFFF_FFF8; exp_pc[1][1] = 32'hFFFF_FFFC; exp_pc[1][2] = 32'h0; exp_pc[1][3] = 32'h4;
        exp_pc[2][0] = 32'hFFFF_FFFE; exp_pc[2][1] = 32'hFFFF_FFFF; exp_pc[2][2] = 32'h0; exp_pc[2][3] = 32'h1;
        for (int i = 0; i < 3; i++) begin
            exp_wr[i][0] = 1'b0; exp_wr[i][1] = 1'b0; exp_wr[i][3] = 1'b0;
            exp_wr[i][2] = (i != 0);
        end

        #2;
        do_reset();
        check_const("reset_valid", {29'd0, d_valid}, 32'd0);
        check_const("reset_pc0", d_pc[0], 32'h0);

        // Table: vectors judged on instance 0, every instance against the model.
        for (int r = 0; r < 23; r++) begin
            stall          = tbl[r].stall;
            redirect_valid = tbl[r].rv;
            redirect_pc    = tbl[r].rpc;
            fetch_ready    = tbl[r].ready;
            tick();
            n_vec++;
            if (d_valid[0] !== tbl[r].ev || d_pc[0] !== tbl[r].epc || d_npc[0] !== tbl[r].epc + 32'd4 ||
                d_pend[0] !== tbl[r].epend || d_kill[0] !== tbl[r].ekill || d_wrap[0] !== tbl[r].ewrap) begin
                n_bad++;
                $display("FAIL row%0d: got v=%b pc=%h npc=%h pend=%b kill=%b wrap=%b, want v=%b pc=%h pend=%b kill=%b wrap=%b",
                         r, d_valid[0], d_pc[0], d_npc[0], d_pend[0], d_kill[0], d_wrap[0],
                         tbl[r].ev, tbl[r].epc, tbl[r].epend, tbl[r].ekill, tbl[r].ewrap);
            end
        end

        // Free-running fetch from reset, including the wrap past 2^32.
        do_reset();
        fetch_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                check_const($sformatf("run_pc i%0d c%0d", i, c), d_pc[i], exp_pc[i][c]);
                check_const($sformatf("run_wrap i%0d c%0d", i, c), {31'd0, d_wrap[i]}, {31'd0, exp_wr[i][c]});
                check_const($sformatf("run_valid i%0d c%0d", i, c), {31'd0, d_valid[i]}, 32'd1);
            end
        end

        // Reset asserted mid-cycle while stalled with a redirect parked.
        do_reset();
        stall = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h800;
        tick();
        check_const("park_pend", {31'd0, d_pend[0]}, 32'd1);
        redirect_valid = 1'b0;
        #2;
        do_reset();
        check_const("rst_pend", {29'd0, d_pend}, 32'd0);
        check_const("rst_valid", {29'd0, d_valid}, 32'd0);
        check_const("rst_pc1", d_pc[1], 32'hFFFF_FFF8);
        fetch_ready = 1'b1;
        tick();
        check_const("restart_pc0", d_pc[0], 32'h0);
        check_const("restart_valid", {29'd0, d_valid}, 32'd7);
        tick();
        check_const("restart_nokill", {29'd0, d_kill}, 32'd0);
        check_const("restart_pc0b", d_pc[0], 32'h4);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                stall          = ($urandom_range(0, 3) == 0);
                redirect_valid = ($urandom_range(0, 4) == 0);
                redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                             : $urandom;
                fetch_ready    = ($urandom_range(0, 2) != 0);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
